// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage elastic register pipeline with per-stage valid bits,
// bubble collapse under backpressure, synchronous flush and a valid-stage count.
// Optional feature: define REG_PIPE_PARITY_EN to carry an even-parity bit with
// every word and flag a mismatch on the output (adds ports par_inject, par_err).
module reg_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef REG_PIPE_PARITY_EN
    ,
    input  logic                       par_inject,
    output logic                       par_err
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAST  = DEPTH - 1;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] adv_c;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             xfer_in_c;
    logic             xfer_out_c;

    // Advance chain: a stage moves when it is empty or its successor moves;
    // ready ripples combinationally from out_ready back to stage 0.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        for (int i = int'(LAST); i >= 0; i--) begin
            adv_c[i] = !valid_q[i] || nxt;
            nxt      = adv_c[i];
        end
    end

    // Handshake outputs; flush blocks both transfers for its cycle.
    always_comb begin
        in_ready   = adv_c[0] && !flush;
        out_valid  = valid_q[LAST] && !flush;
        out_data   = data_q[LAST];
        xfer_in_c  = in_valid && in_ready;
        xfer_out_c = out_valid && out_ready;
    end

    // Stage next-state: advancing stages take their predecessor, others hold.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            data_d[i] = data_q[i];
        end
        if (adv_c[0]) begin
            valid_d[0] = xfer_in_c;
            if (xfer_in_c) begin
                data_d[0] = in_data;
            end
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (adv_c[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Occupancy count tracks transfers in and out; flush empties it.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(xfer_in_c) - CNT_W'(xfer_out_c);
        end
    end

    // Stage and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign count = count_q;

`ifdef REG_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [DEPTH-1:0] par_d;

    // Parity bits move in lockstep with the data they protect.
    always_comb begin
        par_d = par_q;
        if (xfer_in_c) begin
            par_d[0] = (^in_data) ^ par_inject;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (adv_c[i] && valid_q[i-1]) begin
                par_d[i] = par_q[i-1];
            end
        end
    end

    // Parity register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_err = out_valid && ((^out_data) != par_q[LAST]);
`endif

endmodule
